// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one 64-bit data-memory port
// between four requesters. One transaction in flight at a time, with a
// wait-cycle timeout; read data and a done pulse return to the owner.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [3:0]      we_in,
  input  logic [3:0][63:0] addr_in,
  input  logic [3:0][63:0] wdata_in,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [3:0]      done,
  output logic            err,
  output logic [63:0]     rdata,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [63:0]     mem_addr,
  output logic [63:0]     mem_wdata,
  input  logic [63:0]     mem_rdata,
  input  logic            mem_ready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       owner_reg, owner_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       done_reg, done_next;
  logic             err_reg, err_next;
  logic [63:0]      rdata_reg, rdata_next;

  logic [3:0]       eligible;
  logic [3:0]       rot_elig;
  logic             any_elig;
  logic [1:0]       win_ofs;
  logic [1:0]       winner;

  // A requester whose done is pulsing may still hold req; mask it so it
  // is not immediately re-granted.
  assign eligible = req & ~done_reg;
  assign any_elig = |eligible;

  // Rotate the eligible vector so bit 0 is the requester at ptr.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] idx;
      assign idx          = ptr_reg + 2'(gi);
      assign rot_elig[gi] = eligible[idx];
    end
  endgenerate

  // Pick the first eligible requester starting from ptr.
  always_comb begin
    win_ofs = 2'd3;
    if (rot_elig[0])      win_ofs = 2'd0;
    else if (rot_elig[1]) win_ofs = 2'd1;
    else if (rot_elig[2]) win_ofs = 2'd2;
    winner = ptr_reg + win_ofs;
  end

  // Next-state logic: arbitrate in IDLE, wait for handshake or timeout in BUSY.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    done_next  = 4'b0000;
    err_next   = 1'b0;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (any_elig) begin
          state_next = BUSY;
          owner_next = winner;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_next           = mem_rdata;
          done_next[owner_reg] = 1'b1;
          ptr_next             = owner_reg + 2'd1;
          state_next           = IDLE;
        end else if (cnt_reg == CNT_W'(MAX_WAIT - 1)) begin
          done_next[owner_reg] = 1'b1;
          err_next             = 1'b1;
          ptr_next             = owner_reg + 2'd1;
          state_next           = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      owner_reg <= 2'd0;
      ptr_reg   <= 2'd0;
      cnt_reg   <= '0;
      done_reg  <= 4'b0000;
      err_reg   <= 1'b0;
      rdata_reg <= 64'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
    end
  end

  // One-hot grant decoded from the registered owner while busy.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_gnt
      assign gnt[gi] = (state_reg == BUSY) && (owner_reg == 2'(gi));
    end
  endgenerate

  assign mem_valid = (state_reg == BUSY);
  assign sel       = owner_reg;
  assign mem_we    = mem_valid & we_in[owner_reg];
  assign mem_addr  = addr_in[owner_reg];
  assign mem_wdata = wdata_in[owner_reg];
  assign done      = done_reg;
  assign err       = err_reg;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants
// and completions, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       req = 4'b0;
  logic [3:0]       we_in = 4'b0;
  logic [3:0][63:0] addr_in;
  logic [3:0][63:0] wdata_in;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [3:0]       done;
  logic             err;
  logic [63:0]      rdata;
  logic             mem_valid;
  logic             mem_we;
  logic [63:0]      mem_addr;
  logic [63:0]      mem_wdata;
  logic [63:0]      mem_rdata;
  logic             mem_ready;
  logic             ready_en = 1'b1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int          idx;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } gnt_exp_t;

  typedef struct {
    logic [3:0]  done;
    logic        err;
    logic [63:0] rdata;
    int          vcycles;
  } done_exp_t;

  gnt_exp_t  gq[$];
  done_exp_t dq[$];

  mem_port_arbiter #(.MAX_WAIT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req(req), .we_in(we_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .sel(sel),
    .done(done), .err(err), .rdata(rdata), .mem_valid(mem_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: data is a fixed function of the address.
  function automatic logic [63:0] rd_model(input logic [63:0] a);
    if (a == 64'h100) return 64'hDEADBEEF;
    return {a[31:0] ^ 32'h5A5A5A5A, a[31:0]};
  endfunction

  assign mem_rdata = rd_model(mem_addr);
  assign mem_ready = ready_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_txn(input int i, input logic e, input int vc);
    gnt_exp_t  g;
    done_exp_t d;
    g.idx = i; g.we = we_in[i]; g.addr = addr_in[i]; g.wdata = wdata_in[i];
    gq.push_back(g);
    d.done = 4'(1 << i); d.err = e;
    d.rdata = e ? 64'hDEADBEEF : rd_model(addr_in[i]);
    d.vcycles = vc;
    dq.push_back(d);
  endtask

  // Monitor: checks each new grant and each completion against the queues.
  logic prev_valid = 1'b0;
  int   vcnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_valid && !prev_valid) begin
        vcnt = 1;
        if (gq.size() == 0) begin
          chk("unexpected_grant", {60'b0, gnt}, 64'h0);
        end else begin
          gnt_exp_t g;
          g = gq.pop_front();
          $display("grant: idx=%0d gnt=%b sel=%0d addr=%h we=%b", g.idx, gnt, sel, mem_addr, mem_we);
          chk("gnt", {60'b0, gnt}, 64'(1 << g.idx));
          chk("sel", {62'b0, sel}, 64'(g.idx));
          chk("mem_addr", mem_addr, g.addr);
          chk("mem_wdata", mem_wdata, g.wdata);
          chk("mem_we", {63'b0, mem_we}, {63'b0, g.we});
        end
      end else if (mem_valid) begin
        vcnt++;
      end
      if (done != 4'b0) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", {60'b0, done}, 64'h0);
        end else begin
          done_exp_t d;
          d = dq.pop_front();
          $display("done: done=%b err=%b rdata=%h valid_cycles=%0d", done, err, rdata, vcnt);
          chk("done", {60'b0, done}, {60'b0, d.done});
          chk("err", {63'b0, err}, {63'b0, d.err});
          chk("rdata", rdata, d.rdata);
          chk("valid_cycles", 64'(vcnt), 64'(d.vcycles));
          chk("gnt_idle_at_done", {60'b0, gnt}, 64'h0);
        end
      end
    end
    prev_valid = mem_valid;
  end

  // Drop each requester's req when its done is seen; sticky ones one cycle later.
  task automatic serve(input logic [3:0] sticky, input int budget);
    logic [3:0] pend;
    int n;
    pend = 4'b0;
    n = 0;
    while ((req != 4'b0 || pend != 4'b0) && n < budget) begin
      @(posedge clk); #1;
      n++;
      req  = req & ~pend;
      pend = done & sticky;
      req  = req & ~(done & ~sticky);
    end
    chk("serve_drained", {60'b0, req | pend}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      addr_in[i]  = 64'h1000 + 64'(16 * i);
      wdata_in[i] = 64'hA000 + 64'(i);
    end
    we_in = 4'b1010;
    req   = 4'b1111;
    #1 reset = 1'b0;

    // Reset held with all requesting: nothing granted.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_gnt", {60'b0, gnt}, 64'h0);
      chk("rst_valid", {63'b0, mem_valid}, 64'h0);
      chk("rst_done", {60'b0, done}, 64'h0);
      chk("rst_sel", {62'b0, sel}, 64'h0);
    end

    // Fairness from reset: 0,1,2,3, then again 0,1,2,3.
    for (int i = 0; i < 4; i++) push_txn(i, 1'b0, 1);
    @(posedge clk); #1 reset = 1'b1;
    serve(4'b0000, 60);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) push_txn(i, 1'b0, 1);
    serve(4'b0000, 60);

    // Single read from requester 2 and its latency.
    we_in[2] = 1'b0;
    addr_in[2] = 64'h100;
    push_txn(2, 1'b0, 1);
    req = 4'b0100;
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      if (done != 4'b0) break;
    end
    chk("read_latency", 64'(n), 64'd2);
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;

    // Timeout on a write from requester 1.
    ready_en = 1'b0;
    push_txn(1, 1'b1, 16);
    req = 4'b0010;
    serve(4'b0000, 40);
    ready_en = 1'b1;

    // Requester 3 lingers after done with requester 0 waiting: 3 then 0.
    push_txn(3, 1'b0, 1);
    push_txn(0, 1'b0, 1);
    req = 4'b1001;
    serve(4'b1000, 30);

    // Lingering sole requester must not be re-granted.
    push_txn(3, 1'b0, 1);
    req = 4'b1000;
    serve(4'b1000, 30);

    // Plain transaction moves ptr to 2.
    push_txn(1, 1'b0, 1);
    req = 4'b0010;
    serve(4'b0000, 30);

    // Reset mid-transaction: outputs drop at once, no done.
    ready_en = 1'b0;
    gq.push_back('{idx: 2, we: we_in[2], addr: addr_in[2], wdata: wdata_in[2]});
    req = 4'b0100;
    n = 0;
    while (!mem_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_started", {63'b0, mem_valid}, 64'h1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_valid", {63'b0, mem_valid}, 64'h0);
    chk("midrst_gnt", {60'b0, gnt}, 64'h0);
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midrst_done", {60'b0, done}, 64'h0);
    end
    // After release ptr restarts at 0: requester 0 before 3.
    push_txn(0, 1'b0, 1);
    push_txn(3, 1'b0, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    ready_en = 1'b1;
    req = 4'b1001;
    serve(4'b0000, 30);

    repeat (4) @(posedge clk);
    #1;
    chk("grant_queue_empty", 64'(gq.size()), 64'h0);
    chk("done_queue_empty", 64'(dq.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 64-bit data-memory port between 4 requesters, e.g. the MEM stage, a debug/loader port, or a register-file dump engine.
- Owns the select for the 4:1 64-bit word muxes that steer the winner's addr/wdata onto the port.
- Issues one transaction at a time, waits for the memory handshake with a timeout, and returns read data and a completion pulse to the owner.

Parameters:
- MAX_WAIT, 16: cycles in BUSY without mem_ready before abort. Legal range 1..2^CNT_W-1.
- CNT_W, 5: width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  4  per-requester request; held until its done
- we_in  in  4  per-requester write enable (1=write, 0=read)
- addr_in  in  4x64 packed [3:0][63:0]  per-requester address
- wdata_in  in  4x64 packed [3:0][63:0]  per-requester write data
- gnt  out  4  one-hot current owner; 0 when idle
- sel  out  2  encoded owner; drives 4:1 addr/wdata mux selects
- done  out  4  one-cycle completion pulse to owner
- err  out  1  one-cycle pulse with done when the transaction timed out
- rdata  out  64  read data captured at completion; valid while done high
- mem_valid  out  1  transaction presented to memory
- mem_we  out  1  we_in[sel] while mem_valid, else 0
- mem_addr  out  64  addr_in[sel]
- mem_wdata  out  64  wdata_in[sel]
- mem_rdata  in  64  memory read data, valid with mem_ready
- mem_ready  in  1  memory accepts/completes the transaction this cycle

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, gnt=0, sel=0, done=0, err=0, rdata=0, mem_valid=0, wait counter=0, priority pointer ptr=0. Outputs change immediately, not at the next edge.
- States:
  - IDLE: no transaction. mem_valid=0, gnt=0.
  - BUSY: owner registered. mem_valid=1, gnt=onehot(owner), sel=owner.
- Arbitration, IDLE only:
  - Eligible set = req & ~done.
  - The owner whose done is high this cycle is masked, so a requester that has not yet dropped req is not regranted.
  - Winner = first eligible index searching ptr, ptr+1, ... mod 4.
  - If any eligible: next state BUSY, owner=winner, counter=0.
- BUSY, each cycle:
  - mem_ready=1: capture mem_rdata into rdata (reads and writes alike), pulse done[owner] next cycle, err=0, ptr=owner+1 mod 4 (wraps 3->0), go IDLE.
  - Else if counter==MAX_WAIT-1: abort. done[owner]=1 and err=1 next cycle, rdata unchanged, ptr=owner+1, go IDLE.
  - Else counter+1.
- Latency: req high at edge N (IDLE) -> mem_valid high after edge N+1 -> if mem_ready high in that cycle, done high after edge N+2. A granted requester thus completes in at least 2 cycles; back-to-back grants cost one IDLE cycle each.
- mem_addr/mem_wdata/mem_we are combinational through the muxes from the owner's inputs. Requesters must hold them stable while gnt is high.
- Owner deasserts req mid-BUSY: ignored; the transaction runs to completion or timeout and done still pulses.
- Simultaneous requests: strict rotation from ptr. With all 4 requesting continuously, grants go ptr, ptr+1, ... and no requester waits more than 3 other transactions.
- Non-owner req changes during BUSY: no effect until IDLE.
- mem_ready while IDLE: ignored.
- Reset asserted mid-BUSY: transaction dropped, no done, mem_valid low immediately, ptr=0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 -> gnt=0, mem_valid=0, done=0, sel=0. Release -> first grant is requester 0 (gnt=4'b0001).
- Single read:
  - Stimulus: req[2]=1, we_in[2]=0, addr_in[2]=64'h100; mem_ready=1 with mem_rdata=64'hDEADBEEF on the first mem_valid cycle.
  - Response: mem_addr=64'h100, sel=2, mem_we=0; done=4'b0100 two cycles after req; rdata=64'hDEADBEEF; err=0.
- Round-robin fairness: req=4'b1111 held, memory always ready, each requester drops req on its done -> grant order 0,1,2,3. Re-raising all after that -> order restarts at 0 (ptr wrapped 3->0).
- Timeout: MAX_WAIT=16, req[1] write, mem_ready held 0 -> mem_valid high exactly 16 cycles, then done[1]=1 and err=1 for one cycle, rdata unchanged, gnt=0.
- Sticky requester: requester 3 keeps req high one cycle after its done while req[0]=1 -> next grant is 0, not 3.
- Reset mid-transaction: assert reset during BUSY with mem_ready=0 -> mem_valid and gnt drop asynchronously, no done pulse. After release, arbitration restarts from ptr=0.
